rx_buffer: RTL and testbench
============================

// Module: rx_buffer
// PURPOSE
//   Receive-side companion of the matrix transmit path. Collects a stream of
//   bytes from the UART receiver (one i_valid strobe per byte) into a shadow
//   frame of N_BYTES entries. On the last byte it commits the whole frame to
//   o_mat and pulses o_done.
//   An idle timeout and an explicit flush discard partial frames, so the
//   link can resynchronise. o_mat always holds the last complete frame;
//   downstream matrix logic never sees a half-written frame.
// PARAMETERS
//   N_BYTES         9     bytes per frame (3x3 matrix); legal range 1..255
//   TIMEOUT_CYCLES  1000  idle clocks inside a frame before it is discarded;
//                         0 disables the timeout
// PORTS
//   i_clk      in   1           system clock, rising edge
//   i_rst      in   1           reset, synchronous, active-high
//   i_data     in   8           received byte, qualified by i_valid
//   i_valid    in   1           one-cycle strobe: i_data holds a new byte
//   i_flush    in   1           abort any partial frame (one cycle suffices)
//   o_mat      out  8 x N_BYTES last committed frame, o_mat[0] = first byte
//   o_done     out  1           one-cycle pulse: o_mat just updated
//   o_busy     out  1           high while a partial frame is held
//   o_timeout  out  1           one-cycle pulse: partial frame dropped on idle
// BEHAVIOUR
//   - Reset (i_rst high at a rising edge): state IDLE, byte count 0, idle
//     timer 0, shadow and o_mat all 0x00, o_done/o_busy/o_timeout 0.
//     Reset overrides every other input, including mid-frame.
//   - All outputs are registered. o_busy is 1 exactly when state == FILL.
//   - State IDLE: on i_valid, write shadow[0] <= i_data, count <= 1,
//     timer <= 0, go to FILL. If N_BYTES == 1, commit instead (see below)
//     and stay in IDLE.
//   - State FILL: on i_valid, write shadow[count] <= i_data, count += 1,
//     timer <= 0.
//   - Commit: when the accepted byte is index N_BYTES-1, at that same edge
//     o_mat <= {shadow[0..N_BYTES-2], i_data} and o_done <= 1.
//     Count returns to 0 and the state goes to IDLE.
//     Latency: o_mat and o_done change 1 clock after the last i_valid cycle.
//   - o_mat changes only on commit. It is stable during filling, flush,
//     and timeout.
//   - Idle timeout (TIMEOUT_CYCLES > 0): in FILL, each clock without i_valid
//     increments the timer. When the timer equals TIMEOUT_CYCLES-1 and no
//     i_valid is present, the block drops the frame: count <= 0, state IDLE,
//     o_timeout <= 1 for one cycle.
//     If i_valid arrives in that same cycle, the byte wins: it is accepted
//     and no timeout occurs.
//   - i_flush: in FILL, abandon the frame (count 0, state IDLE, timer 0),
//     with no o_timeout and no o_done. In IDLE, i_flush is a no-op.
//     i_flush together with i_valid: flush wins and the byte is discarded.
//   - Back-to-back frames: i_valid in the cycle right after a commit starts
//     the next frame normally (no dead cycle).
//   - No backpressure: a byte is never refused except under flush or reset.
//     The upstream byte rate is bounded by the UART, so no overrun case exists.
//   - Widths: count is $clog2(N_BYTES+1) bits and never exceeds N_BYTES-1.
//     Timer is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
// STRUCTURE
//   - Shared package icecube_pkg holds: MAT_BYTES = 9, typedef logic [7:0]
//     byte_t, and typedef enum {RX_IDLE, RX_FILL} rx_state_t.
//   - One sub-module, rx_idle_timer: clear / enable / expire, parameterised
//     by TIMEOUT_CYCLES. It is tied off when TIMEOUT_CYCLES == 0.
//   - The shadow array and the o_mat array are separate registers.
// TESTING
//   1. Nine i_valid strobes, back to back, data 0x01..0x09 -> o_done is one
//      1-cycle pulse the clock after byte 9; o_mat[0..8] = 01..09; o_busy
//      1 from byte 1 through byte 9, then 0.
//   2. With TIMEOUT_CYCLES=16: send 4 bytes, then idle -> o_timeout pulses
//      16 clocks after the 4th byte, o_busy drops, o_mat keeps the prior frame.
//      Then 9 bytes 0xA0..0xA8 -> o_mat = A0..A8 (index 0 realigned).
//   3. Byte 5 of a frame arrives exactly in the expiry cycle -> it is
//      accepted, no o_timeout; the frame later completes with correct order.
//   4. After 3 bytes, i_flush and i_valid(0xFF) in the same cycle -> byte
//      dropped, o_busy 0, no pulses. The next 9 bytes commit with 0xFF absent.
//   5. i_rst held 1 cycle after 5 bytes of a frame -> o_mat all 0x00, all
//      flags 0; a fresh 9-byte frame then commits correctly.
//   6. Two frames back to back (18 strobes, no gaps) -> two o_done pulses
//      9 clocks apart; o_mat holds frame 1 unchanged until frame 2's commit.

Source files
------------

// File: rtl/icecube_pkg.sv
// Shared types for the matrix link: frame size, byte type, receive states.
package icecube_pkg;

    localparam int MAT_BYTES = 9;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_FILL = 1'b1
    } rx_state_t;

endpackage

// File: rtl/rx_idle_timer.sv
// Idle timer for a partial frame: cleared on activity, counts idle clocks,
// flags expiry on the last allowed idle clock. Saturates instead of wrapping.
module rx_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] MAX  = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer;

    // Count idle clocks; clear has priority, hold at MAX so it never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst || clear) begin
            timer <= '0;
        end else if (enable && timer != MAX) begin
            timer <= timer + 1'b1;
        end
    end

    assign expire = enable && (timer == LAST);

endmodule

// File: rtl/rx_buffer.sv
// Collects UART bytes into a shadow frame and commits the complete frame to
// o_mat in one edge, so downstream logic never sees a half-written matrix.
// Partial frames are dropped on flush or on an idle timeout.
module rx_buffer
    import icecube_pkg::*;
#(
    parameter int N_BYTES        = MAT_BYTES,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  byte_t                 i_data,
    input  logic                  i_valid,
    input  logic                  i_flush,
    output byte_t [N_BYTES-1:0]   o_mat,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int CW = $clog2(N_BYTES + 1);

    rx_state_t            state;
    logic [CW-1:0]        count;
    byte_t [N_BYTES-1:0]  shadow;
    byte_t [N_BYTES-1:0]  mat_next;
    logic                 last_byte;
    logic                 tmr_clear;
    logic                 tmr_enable;
    logic                 expire;

    // In IDLE count is 0, so N_BYTES == 1 commits straight from IDLE.
    assign last_byte  = (count == CW'(N_BYTES - 1));
    assign tmr_clear  = (state != RX_FILL) || i_valid || i_flush;
    assign tmr_enable = (state == RX_FILL) && !i_valid;
    assign o_busy     = (state == RX_FILL);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            rx_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .clear  (tmr_clear),
                .enable (tmr_enable),
                .expire (expire)
            );
        end else begin : g_no_timer
            assign expire = 1'b0;
        end
    endgenerate

    // Frame to commit: bytes already held plus the byte arriving now.
    always_comb begin
        mat_next            = shadow;
        mat_next[N_BYTES-1] = i_data;
    end

    // Receive FSM: flush beats a byte, a byte beats the timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= RX_IDLE;
            count     <= '0;
            shadow    <= '0;
            o_mat     <= '0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            if (i_flush) begin
                state <= RX_IDLE;
                count <= '0;
            end else if (i_valid) begin
                if (last_byte) begin
                    o_mat  <= mat_next;
                    o_done <= 1'b1;
                    count  <= '0;
                    state  <= RX_IDLE;
                end else begin
                    for (int i = 0; i < N_BYTES; i++) begin
                        if (count == CW'(i)) shadow[i] <= i_data;
                    end
                    count <= count + 1'b1;
                    state <= RX_FILL;
                end
            end else if (expire) begin
                state     <= RX_IDLE;
                count     <= '0;
                o_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_buffer.sv
// Directed bench for rx_buffer: 9-byte frames, 16-clock idle timeout.
module tb_rx_buffer;
    import icecube_pkg::*;

    localparam int NB = 9;

    logic             i_clk = 1'b0;
    logic             i_rst;
    byte_t            i_data;
    logic             i_valid;
    logic             i_flush;
    byte_t [NB-1:0]   o_mat;
    logic             o_done;
    logic             o_busy;
    logic             o_timeout;

    int checks = 0;
    int errors = 0;

    rx_buffer #(.N_BYTES(NB), .TIMEOUT_CYCLES(16)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_flush   (i_flush),
        .o_mat     (o_mat),
        .o_done    (o_done),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Apply inputs for one edge, then settle just past it for sampling.
    task automatic tick(input logic v, input byte_t d, input logic f);
        i_valid = v;
        i_data  = d;
        i_flush = f;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic send(input byte_t base, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, byte_t'(base + i), 1'b0);
    endtask

    task automatic chk(input string tag, input logic [NB*8-1:0] obs, input logic [NB*8-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*8-1:0] frame(input byte_t base);
        logic [NB*8-1:0] f;
        for (int i = 0; i < NB; i++) f[i*8 +: 8] = byte_t'(base + i);
        return f;
    endfunction

    initial begin
        i_rst = 1'b1; i_data = '0; i_valid = 1'b0; i_flush = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h5A, 1'b0);
        i_rst = 1'b0;
        chk("rst_mat", o_mat, '0);
        chk("rst_done", o_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_tmo", o_timeout, 0);

        // 1: one back-to-back frame 01..09
        for (int i = 0; i < NB - 1; i++) begin
            tick(1'b1, byte_t'(i + 1), 1'b0);
            chk("t1_busy", o_busy, 1);
            chk("t1_nodone", o_done, 0);
        end
        tick(1'b1, 8'h09, 1'b0);
        chk("t1_done", o_done, 1);
        chk("t1_busy_lo", o_busy, 0);
        chk("t1_mat", o_mat, frame(8'h01));
        tick(1'b0, 8'h00, 1'b0);
        chk("t1_done_pulse", o_done, 0);
        chk("t1_mat_hold", o_mat, frame(8'h01));

        // 2: 4 bytes then idle -> timeout 16 clocks after the 4th byte
        send(8'h11, 4);
        for (int k = 1; k < 16; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            chk("t2_no_tmo", o_timeout, 0);
        end
        chk("t2_busy_pre", o_busy, 1);
        tick(1'b0, 8'h00, 1'b0);
        chk("t2_tmo", o_timeout, 1);
        chk("t2_busy_lo", o_busy, 0);
        chk("t2_mat_kept", o_mat, frame(8'h01));
        tick(1'b0, 8'h00, 1'b0);
        chk("t2_tmo_pulse", o_timeout, 0);
        send(8'hA0, NB);
        chk("t2_done", o_done, 1);
        chk("t2_mat", o_mat, frame(8'hA0));

        // 3: byte 5 lands exactly in the expiry cycle
        send(8'h21, 4);
        for (int k = 1; k < 16; k++) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h25, 1'b0);
        chk("t3_no_tmo", o_timeout, 0);
        chk("t3_busy", o_busy, 1);
        send(8'h26, 4);
        chk("t3_done", o_done, 1);
        chk("t3_mat", o_mat, frame(8'h21));

        // 4: flush together with a byte after 3 bytes
        send(8'h31, 3);
        tick(1'b1, 8'hFF, 1'b1);
        chk("t4_busy", o_busy, 0);
        chk("t4_done", o_done, 0);
        chk("t4_tmo", o_timeout, 0);
        chk("t4_mat_kept", o_mat, frame(8'h21));
        send(8'h41, NB);
        chk("t4_done2", o_done, 1);
        chk("t4_mat", o_mat, frame(8'h41));

        // 5: reset mid-frame
        send(8'h51, 5);
        i_rst = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        i_rst = 1'b0;
        chk("t5_mat", o_mat, '0);
        chk("t5_busy", o_busy, 0);
        chk("t5_done", o_done, 0);
        chk("t5_tmo", o_timeout, 0);
        send(8'h61, NB);
        chk("t5_done2", o_done, 1);
        chk("t5_mat2", o_mat, frame(8'h61));

        // 6: two frames back to back, no gap
        send(8'h71, NB);
        chk("t6_done1", o_done, 1);
        chk("t6_mat1", o_mat, frame(8'h71));
        for (int i = 0; i < NB - 1; i++) begin
            tick(1'b1, byte_t'(8'h7A + i), 1'b0);
            chk("t6_nodone", o_done, 0);
            chk("t6_mat_hold", o_mat, frame(8'h71));
        end
        tick(1'b1, 8'h82, 1'b0);
        chk("t6_done2", o_done, 1);
        chk("t6_mat2", o_mat, frame(8'h7A));

        // idle in IDLE never times out
        for (int k = 0; k < 20; k++) tick(1'b0, 8'h00, 1'b0);
        chk("idle_no_tmo", o_timeout, 0);
        chk("idle_busy", o_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
